// File: rtl/ps2_pkg.sv
// ps2_pkg
//  Shared definitions for the PS/2 host interface blocks:
//   - ps2_tx_state_t : transmitter state encoding
//   - PS/2 command / response byte constants
//   - odd_parity()   : parity bit that makes data+parity carry an odd number of ones
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE,
    DONE
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync
//  Multi-stage synchronizer for the raw ps2_clk / ps2_data line levels, plus a
//  one-cycle falling-edge strobe on the synchronized clock. Shared with the
//  receive side.
// Ports
//  clk        in  system clock
//  clr        in  synchronous reset, active-high (pipes preset to idle-high)
//  ps2_clk    in  raw clock line level
//  ps2_data   in  raw data line level
//  clk_sync   out synchronized clock line
//  data_sync  out synchronized data line (same latency as clk_sync)
//  clk_fe     out one-cycle pulse: synced clock was 1, is now 0
module ps2_line_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fe
);

  logic [SYNC_STAGES-1:0] clk_pipe_reg;
  logic [SYNC_STAGES-1:0] data_pipe_reg;
  logic                   clk_prev_reg;

  // Preset to 1 so that an idle bus does not produce a false edge after reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      clk_pipe_reg  <= '1;
      data_pipe_reg <= '1;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_pipe_reg  <= {clk_pipe_reg[SYNC_STAGES-2:0], ps2_clk};
      data_pipe_reg <= {data_pipe_reg[SYNC_STAGES-2:0], ps2_data};
      clk_prev_reg  <= clk_pipe_reg[SYNC_STAGES-1];
    end
  end

  assign clk_sync  = clk_pipe_reg[SYNC_STAGES-1];
  assign data_sync = data_pipe_reg[SYNC_STAGES-1];
  assign clk_fe    = clk_prev_reg & ~clk_pipe_reg[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//  Host-to-device PS/2 transmitter: inhibits the bus, issues the start bit,
//  shifts one byte + odd parity + stop on device-generated falling edges,
//  samples the device ack and waits for the bus to return idle.
//  Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a transfer after
//  TIMEOUT_CYCLES clk cycles from accept (tx_timeout reports it).
// Ports
//  clk, clr                   clock, synchronous active-high reset
//  tx_data, tx_valid/tx_ready byte request handshake (accept = valid & ready)
//  tx_busy                    high whenever not IDLE
//  tx_done                    one-cycle end-of-transfer pulse
//  tx_ack_err, tx_timeout     result flags, valid with tx_done, held until next accept
//  ps2_clk, ps2_data          raw line levels
//  ps2_clk_oe, ps2_data_oe    1 = pull the line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 1);

  logic clk_sync;
  logic data_sync;
  logic clk_fe;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .clr       (clr),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fe    (clk_fe)
  );

  ps2_tx_state_t    state_reg, state_next;
  logic [7:0]       shreg_reg, shreg_next;
  logic             par_reg, par_next;
  logic [3:0]       bitcnt_reg, bitcnt_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic             data_oe_reg, data_oe_next;
  logic             ack_err_reg, ack_err_next;
  logic             timeout_reg, timeout_next;
  logic             wd_expired;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_reg;

  // Counts from the accept edge; the comparison against TIMEOUT_CYCLES-1
  // makes DONE land exactly TIMEOUT_CYCLES edges after accept. DONE itself
  // is excluded so an expiry there cannot re-enter DONE.
  always_ff @(posedge clk) begin
    if (clr) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      wd_cnt_reg <= '0;
    end else if (wd_cnt_reg != WD_LAST) begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  assign wd_expired = (state_reg != IDLE) && (state_reg != DONE) && (wd_cnt_reg == WD_LAST);
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
  assign wd_expired = 1'b0;
`endif

  function automatic logic [3:0] bit_inc(input logic [3:0] b);
    return (b == 4'd11) ? 4'd11 : b + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      par_reg     <= 1'b0;
      bitcnt_reg  <= '0;
      inh_cnt_reg <= '0;
      data_oe_reg <= 1'b0;
      ack_err_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      par_reg     <= par_next;
      bitcnt_reg  <= bitcnt_next;
      inh_cnt_reg <= inh_cnt_next;
      data_oe_reg <= data_oe_next;
      ack_err_reg <= ack_err_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    par_next     = par_reg;
    bitcnt_next  = bitcnt_reg;
    inh_cnt_next = inh_cnt_reg;
    data_oe_next = data_oe_reg;
    ack_err_next = ack_err_reg;
    timeout_next = timeout_reg;

    case (state_reg)
      IDLE: begin
        if (tx_valid) begin
          shreg_next   = tx_data;
          par_next     = odd_parity(tx_data);
          inh_cnt_next = '0;
          bitcnt_next  = '0;
          data_oe_next = 1'b0;
          ack_err_next = 1'b0;
          timeout_next = 1'b0;
          state_next   = INHIBIT;
        end
      end
      INHIBIT: begin
        // Clock is held low for INHIBIT_CYCLES with data released, then one
        // more cycle with the start bit already on the data line.
        if (inh_cnt_reg == INH_LAST) begin
          state_next = REQ;
        end else begin
          inh_cnt_next = inh_cnt_reg + 1'b1;
          if (inh_cnt_reg == INH_PRE) begin
            data_oe_next = 1'b1;
          end
        end
      end
      REQ: begin
        if (clk_fe) begin
          bitcnt_next  = 4'd1;
          data_oe_next = ~shreg_reg[0];
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (clk_fe) begin
          bitcnt_next = bit_inc(bitcnt_reg);
          // bitcnt_reg holds the edges seen so far, which is also the index
          // of the next data bit to present.
          case (bitcnt_reg)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
              data_oe_next = ~shreg_reg[bitcnt_reg[2:0]];
            4'd8:
              data_oe_next = ~par_reg;
            4'd9: begin
              data_oe_next = 1'b0;
              state_next   = ACK;
            end
            default: ;
          endcase
        end
      end
      ACK: begin
        if (clk_fe) begin
          bitcnt_next  = bit_inc(bitcnt_reg);
          ack_err_next = data_sync;
          state_next   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        data_oe_next = 1'b0;
      end
    endcase

    // Watchdog overrides everything else, including a same-cycle edge.
    if (wd_expired) begin
      state_next   = DONE;
      data_oe_next = 1'b0;
      timeout_next = 1'b1;
      ack_err_next = 1'b0;
    end
  end

  assign tx_ready    = (state_reg == IDLE);
  assign tx_busy     = (state_reg != IDLE);
  assign tx_done     = (state_reg == DONE);
  assign tx_ack_err  = ack_err_reg;
  assign tx_timeout  = timeout_reg;
  assign ps2_clk_oe  = (state_reg == INHIBIT);
  assign ps2_data_oe = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//  Bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
//  The device clocks 11 pulses after the host start condition, samples the
//  wire on rising edges and optionally drives the ack. Expected wire bits
//  come from the byte by plain arithmetic. Define PS2_TX_TIMEOUT_EN to also
//  exercise the watchdog.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TO   = 3000;
  localparam int SYNC = 3;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_ack_err, tx_timeout;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = !(ps2_clk_oe || dev_clk_low);
  assign ps2_data_line = !(ps2_data_oe || dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .clr         (clr),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_ack_err  (tx_ack_err),
    .tx_timeout  (tx_timeout),
    .ps2_clk     (ps2_clk_line),
    .ps2_data    (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int done_cnt = 0, accept_cnt = 0;
  int done_cyc = 0, accept_edge = 0;
  int oe_run = 0, last_run = 0;
  logic last_ack_err = 1'b0, last_timeout = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt     <= done_cnt + 1;
      done_cyc     <= cyc;
      last_ack_err <= tx_ack_err;
      last_timeout <= tx_timeout;
    end
    if (tx_valid && tx_ready) begin
      accept_cnt  <= accept_cnt + 1;
      accept_edge <= cyc + 1;
    end
    if (ps2_clk_oe) begin
      oe_run <= oe_run + 1;
    end else if (oe_run > 0) begin
      last_run <= oe_run;
      oe_run   <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference wire image: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] wire_image(input logic [7:0] b);
    logic [10:0] w;
    int ones = 0;
    w[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w[i+1] = ((b >> i) & 1) != 0;
      ones += (b >> i) & 1;
    end
    w[9]  = (ones % 2) == 0;
    w[10] = 1'b1;
    return w;
  endfunction

  // Device side of one frame. abort_at>0 pulses clr shortly after that
  // falling edge and abandons the frame.
  task automatic dev_frame(input int abort_at, input bit give_ack,
                           output logic [10:0] seen, output bit ok);
    int t = 0;
    ok   = 1'b1;
    seen = '0;
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0)) begin
      @(posedge clk); #1;
      t++;
      if (t > 5000) begin
        ok = 1'b0;
        return;
      end
    end
    seen[0] = ps2_data_line;
    for (int k = 1; k <= 11; k++) begin
      repeat (HALF) @(posedge clk);
      #1 dev_clk_low = 1'b1;
      if (k == abort_at) begin
        repeat (8) @(posedge clk);
        #1 check_eq("pre_clr_data_oe", ps2_data_oe, 1'b1);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        check_eq("clr_clk_oe", ps2_clk_oe, 1'b0);
        check_eq("clr_data_oe", ps2_data_oe, 1'b0);
        check_eq("clr_ready", tx_ready, 1'b1);
        dev_clk_low = 1'b0;
        return;
      end
      repeat (HALF) @(posedge clk);
      #1 dev_clk_low = 1'b0;
      if (k <= 10) seen[k] = ps2_data_line;
      if (k == 10) dev_data_low = give_ack;
    end
    repeat (HALF) @(posedge clk);
    #1 dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int bound);
    int t = 0;
    while (done_cnt == prev && t < bound) begin
      @(negedge clk); #1;
      t++;
    end
    check_eq("done_seen", done_cnt != prev, 1'b1);
  endtask

  task automatic send(input logic [7:0] b, input bit give_ack);
    logic [10:0] seen;
    bit ok;
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    dev_frame(0, give_ack, seen, ok);
    check_eq("start_found", ok, 1'b1);
    wait_done(d0, 3000);
    check_eq("wire_bits", seen, wire_image(b));
    check_eq("ack_err", last_ack_err, !give_ack);
    check_eq("timeout", last_timeout, 1'b0);
    check_eq("inhibit_len", last_run, INH + 1);
    check_eq("done_once", done_cnt, d0 + 1);
    @(negedge clk); #1;
    check_eq("post_clk_oe", ps2_clk_oe, 1'b0);
    check_eq("post_data_oe", ps2_data_oe, 1'b0);
    check_eq("post_ready", tx_ready, 1'b1);
    $display("send 0x%02h ack=%0d wire=%011b ack_err=%0d", b, give_ack, seen, last_ack_err);
  endtask

  initial begin
    logic [10:0] seen;
    bit ok;
    int d0, a0;

    repeat (4) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", tx_ready, 1'b1);
    check_eq("rst_busy", tx_busy, 1'b0);
    check_eq("rst_done", tx_done, 1'b0);
    check_eq("rst_flags", {tx_ack_err, tx_timeout}, 2'b00);
    check_eq("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    send(8'hED, 1'b1);
    send(8'hF4, 1'b1);
    send(8'h5A, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
    end

    // Reset mid-frame at fe5 of 0x00.
    d0 = done_cnt;
    @(posedge clk); #1;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    dev_frame(5, 1'b1, seen, ok);
    check_eq("abort_start_found", ok, 1'b1);
    repeat (60) @(negedge clk);
    #1 check_eq("abort_no_done", done_cnt, d0);
    $display("abort 0x00 at fe5 done_cnt=%0d", done_cnt);
    send(8'h3C, 1'b1);

    // tx_valid held high across a whole transfer.
    d0 = done_cnt;
    a0 = accept_cnt;
    @(posedge clk); #1;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    dev_frame(0, 1'b1, seen, ok);
    check_eq("hold_start_found", ok, 1'b1);
    wait_done(d0, 3000);
    check_eq("hold_wire", seen, wire_image(8'hFF));
    check_eq("hold_one_accept", accept_cnt, a0 + 1);
    @(negedge clk); #1;
    check_eq("hold_second_accept", accept_cnt, a0 + 2);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    dev_frame(0, 1'b1, seen, ok);
    wait_done(d0 + 1, 3000);
    check_eq("hold_wire2", seen, wire_image(8'hFF));
    check_eq("hold_dones", done_cnt, d0 + 2);
    repeat (5) @(negedge clk);
    #1 check_eq("hold_total_accepts", accept_cnt, a0 + 2);
    $display("held-valid 0xFF accepts=%0d dones=%0d", accept_cnt - a0, done_cnt - d0);

`ifdef PS2_TX_TIMEOUT_EN
    // Silent device: watchdog ends the transfer.
    d0 = done_cnt;
    @(posedge clk); #1;
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_done(d0, TO + 200);
    check_eq("to_latency", done_cyc - accept_edge, TO);
    check_eq("to_flag", last_timeout, 1'b1);
    check_eq("to_ack_err", last_ack_err, 1'b0);
    check_eq("to_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    $display("timeout 0xAA latency=%0d", done_cyc - accept_edge);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
